vga_text_console: RTL

- Console write controller for the 80x60 text-mode VGA display.
- Accepts a stream of ASCII characters and control codes from the CPU/keyboard side, and maintains a cursor.
- Generates the screen-buffer write port: VGA_we, write_addr, and ASCII as {bg[7:0], fg[7:0], char[7:0]}.
- Sequences multi-cycle line-clear and screen-clear operations so the display never holds codes below 0x20, which the font lookup cannot index.

---
 rtl/vga_text_console.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/vga_text_console.sv
// rtl/vga_text_console.sv - 80x60 text console write controller: cursor, control codes, line/screen clear sequencing.
module vga_text_console #(
    parameter int          COLS   = 80,
    parameter int          ROWS   = 60,
    parameter logic [7:0]  BLANK  = 8'h20,
    parameter logic [7:0]  DEF_FG = 8'hFF,
    parameter logic [7:0]  DEF_BG = 8'h00
) (
    input  logic        clk_in,
    input  logic        rst_out,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        color_we,
    input  logic [15:0] color_in,
    input  logic        clear_req,
    output logic        busy,
    output logic        VGA_we,
    output logic [12:0] write_addr,
    output logic [23:0] ASCII,
    output logic [5:0]  cursor_row,
    output logic [6:0]  cursor_col
);

    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

    localparam logic [12:0] LAST_ADDR = 13'(ROWS * COLS - 1);
    localparam logic [6:0]  COL_MAX   = 7'(COLS - 1);
    localparam logic [5:0]  ROW_MAX   = 6'(ROWS - 1);

    function automatic logic [12:0] line_base(input logic [5:0] r);
        return 13'(r) * 13'(COLS);
    endfunction

    state_t      state, state_nxt;
    logic [7:0]  fg, bg, fg_nxt, bg_nxt;
    logic        clear_pending, pend_nxt;
    logic [12:0] clr_addr, clr_addr_nxt;
    logic [12:0] clr_end, clr_end_nxt;
    logic        clr_done, clr_done_nxt;
    logic [5:0]  row_nxt;
    logic [6:0]  col_nxt;
    logic        we_nxt;
    logic [12:0] addr_nxt;
    logic [23:0] data_nxt;
    logic [5:0]  row_inc;
    logic [12:0] cur_base, inc_base;
    logic        printable;

    assign row_inc   = (cursor_row == ROW_MAX) ? 6'd0 : cursor_row + 6'd1;
    assign cur_base  = line_base(cursor_row);
    assign inc_base  = line_base(row_inc);
    assign printable = (char_data >= 8'h20) && (char_data <= 8'h7E);

    always_comb begin
        state_nxt    = state;
        row_nxt      = cursor_row;
        col_nxt      = cursor_col;
        we_nxt       = 1'b0;
        addr_nxt     = write_addr;
        data_nxt     = ASCII;
        clr_addr_nxt = clr_addr;
        clr_end_nxt  = clr_end;
        clr_done_nxt = clr_done;
        pend_nxt     = clear_pending | (clear_req & (state != IDLE));
        fg_nxt       = fg;
        bg_nxt       = bg;
        if (color_we) begin
            {bg_nxt, fg_nxt} = color_in;
        end

        case (state)
            IDLE: begin
                if (clear_pending || clear_req) begin
                    state_nxt    = CLR_ALL;
                    clr_addr_nxt = 13'd0;
                    clr_end_nxt  = LAST_ADDR;
                    clr_done_nxt = 1'b0;
                    pend_nxt     = 1'b0;
                end else if (char_valid && char_ready) begin
                    if (printable) begin
                        we_nxt   = 1'b1;
                        addr_nxt = cur_base + 13'(cursor_col);
                        data_nxt = {bg, fg, char_data};
                        if (cursor_col == COL_MAX) begin
                            row_nxt      = row_inc;
                            col_nxt      = 7'd0;
                            state_nxt    = CLR_LINE;
                            clr_addr_nxt = inc_base;
                            clr_end_nxt  = inc_base + 13'(COL_MAX);
                            clr_done_nxt = 1'b0;
                        end else begin
                            col_nxt = cursor_col + 7'd1;
                        end
                    end else if (char_data == 8'h0A) begin
                        row_nxt      = row_inc;
                        col_nxt      = 7'd0;
                        state_nxt    = CLR_LINE;
                        clr_addr_nxt = inc_base;
                        clr_end_nxt  = inc_base + 13'(COL_MAX);
                        clr_done_nxt = 1'b0;
                    end else if (char_data == 8'h0D) begin
                        col_nxt = 7'd0;
                    end else if (char_data == 8'h08) begin
                        if (cursor_col != 7'd0) begin
                            col_nxt  = cursor_col - 7'd1;
                            we_nxt   = 1'b1;
                            addr_nxt = cur_base + 13'(cursor_col) - 13'd1;
                            data_nxt = {bg, fg, BLANK};
                        end else if (cursor_row != 6'd0) begin
                            // Backing over a row boundary blanks the last cell of the row being left.
                            row_nxt  = cursor_row - 6'd1;
                            col_nxt  = COL_MAX;
                            we_nxt   = 1'b1;
                            addr_nxt = cur_base + 13'(COL_MAX);
                            data_nxt = {bg, fg, BLANK};
                        end
                    end
                end
            end
            CLR_LINE, CLR_ALL: begin
                if (!clr_done) begin
                    we_nxt   = 1'b1;
                    addr_nxt = clr_addr;
                    data_nxt = {bg, fg, BLANK};
                    if (clr_addr == clr_end) begin
                        clr_done_nxt = 1'b1;
                    end else begin
                        clr_addr_nxt = clr_addr + 13'd1;
                    end
                end else begin
                    // One settle cycle after the final write so busy drops after it is visible.
                    state_nxt = IDLE;
                    if (state == CLR_ALL) begin
                        row_nxt = 6'd0;
                        col_nxt = 7'd0;
                    end
                end
            end
            default: state_nxt = CLR_ALL;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_out) begin
            state         <= CLR_ALL;
            fg            <= DEF_FG;
            bg            <= DEF_BG;
            clear_pending <= 1'b0;
            clr_addr      <= 13'd0;
            clr_end       <= LAST_ADDR;
            clr_done      <= 1'b0;
            cursor_row    <= 6'd0;
            cursor_col    <= 7'd0;
            VGA_we        <= 1'b0;
            write_addr    <= 13'd0;
            ASCII         <= 24'd0;
            char_ready    <= 1'b0;
            busy          <= 1'b1;
        end else begin
            state         <= state_nxt;
            fg            <= fg_nxt;
            bg            <= bg_nxt;
            clear_pending <= pend_nxt;
            clr_addr      <= clr_addr_nxt;
            clr_end       <= clr_end_nxt;
            clr_done      <= clr_done_nxt;
            cursor_row    <= row_nxt;
            cursor_col    <= col_nxt;
            VGA_we        <= we_nxt;
            write_addr    <= addr_nxt;
            ASCII         <= data_nxt;
            char_ready    <= (state_nxt == IDLE) && !pend_nxt;
            busy          <= (state_nxt != IDLE);
        end
    end

endmodule
